// File: rtl/aiva_ir_pkg.sv
// Shared types and default geometry for the instruction assembler and its length decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aiva_ir_pkg;

    // Assembler FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } ir_state_t;

    // Default fetch-word geometry
    localparam int IR_WORD_W    = 8;
    localparam int IR_MAX_WORDS = 3;

    // Position of the length field inside word 0 (words = field + 1)
    localparam int IR_LEN_MSB   = 7;
    localparam int IR_LEN_LSB   = 6;

endpackage

// File: rtl/ir_len_decode.sv
// Length decode of an instruction's first word: field -> {clamped word count, illegal}.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its input.
//
// Ports:
//   i_field    length field taken from word 0
//   o_len      word count, clamped to MAX_WORDS
//   o_illegal  field+1 exceeded MAX_WORDS (forced low when CHECK_EN=0)
module ir_len_decode
    import aiva_ir_pkg::*;
#(
    parameter int MAX_WORDS = IR_MAX_WORDS,
    parameter int LEN_MSB   = IR_LEN_MSB,
    parameter int LEN_LSB   = IR_LEN_LSB,
    parameter bit CHECK_EN  = 1'b0,
    localparam int LW       = $clog2(MAX_WORDS + 1)
) (
    input  logic [LEN_MSB-LEN_LSB:0] i_field,
    output logic [LW-1:0]            o_len,
    output logic                     o_illegal
);

    logic [31:0] w_words;
    logic        w_over;

    always_comb begin
        w_words   = 32'(i_field) + 32'd1;
        w_over    = (w_words > 32'(MAX_WORDS));
        o_len     = w_over ? LW'(MAX_WORDS) : LW'(w_words);
        o_illegal = CHECK_EN && w_over;
    end

endmodule

// File: rtl/instr_assembler.sv
// Packs a variable-length instruction from fetch words and presents it to the decoder.
// Latency: out_valid rises the cycle after the last word is taken; one word per cycle sustained.
// Backpressure: while an instruction is held, in_ready follows out_ready; a held word waits at the source.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous abort of the partial or held instruction
//   in_valid/in_ready     fetch word handshake, in_word is the data
//   out_valid/out_ready   decoder handshake
//   out_instr             packed instruction, word 0 in the MSBs, unused words zero
//   out_len               word count of the held instruction
//   out_illegal           length field overflowed MAX_WORDS (macro IR_LEN_CHECK_EN)
//
// Macro IR_LEN_CHECK_EN: when defined, overlong length fields flag out_illegal;
// otherwise the clamp to MAX_WORDS is silent and out_illegal stays 0.
module instr_assembler
    import aiva_ir_pkg::*;
#(
    parameter int WORD_W    = IR_WORD_W,
    parameter int MAX_WORDS = IR_MAX_WORDS,
    parameter int LEN_MSB   = IR_LEN_MSB,
    parameter int LEN_LSB   = IR_LEN_LSB,
    localparam int LW       = $clog2(MAX_WORDS + 1),
    localparam int IW       = MAX_WORDS * WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IW-1:0]     out_instr,
    output logic [LW-1:0]     out_len,
    output logic              out_illegal
);

`ifdef IR_LEN_CHECK_EN
    localparam bit LEN_CHK = 1'b1;
`else
    localparam bit LEN_CHK = 1'b0;
`endif

    ir_state_t   r_state, w_state_nxt;
    logic [IW-1:0] r_buf, w_buf_nxt;
    logic [LW-1:0] r_count, w_count_nxt;
    logic [LW-1:0] r_len, w_len_nxt;
    logic          r_illegal, w_illegal_nxt;

    logic [LW-1:0] w_dec_len;
    logic          w_dec_illegal;
    logic          w_xfer;

    ir_len_decode #(
        .MAX_WORDS (MAX_WORDS),
        .LEN_MSB   (LEN_MSB),
        .LEN_LSB   (LEN_LSB),
        .CHECK_EN  (LEN_CHK)
    ) u_len_decode (
        .i_field   (in_word[LEN_MSB:LEN_LSB]),
        .o_len     (w_dec_len),
        .o_illegal (w_dec_illegal)
    );

    always_comb begin
        in_ready      = (r_state == HOLD) ? out_ready : 1'b1;
        out_valid     = (r_state == HOLD);
        w_xfer        = in_valid && in_ready;
        w_state_nxt   = r_state;
        w_buf_nxt     = r_buf;
        w_count_nxt   = r_count;
        w_len_nxt     = r_len;
        w_illegal_nxt = r_illegal;

        unique case (r_state)
            IDLE, HOLD: begin
                // Leaving HOLD without a new word: drop back to IDLE.
                if (r_state == HOLD && out_ready && !in_valid) begin
                    w_state_nxt = IDLE;
                end
                // In HOLD a transfer implies out_ready, so the held instruction
                // is consumed and this word opens the next one with no bubble.
                if (w_xfer) begin
                    w_buf_nxt                     = '0;
                    w_buf_nxt[IW-1 -: WORD_W]     = in_word;
                    w_count_nxt                   = LW'(1);
                    w_len_nxt                     = w_dec_len;
                    w_illegal_nxt                 = w_dec_illegal;
                    w_state_nxt = (w_dec_len == LW'(1)) ? HOLD : COLLECT;
                end
            end
            COLLECT: begin
                if (w_xfer) begin
                    for (int k = 1; k < MAX_WORDS; k++) begin
                        if (r_count == LW'(k)) begin
                            w_buf_nxt[(MAX_WORDS-k)*WORD_W-1 -: WORD_W] = in_word;
                        end
                    end
                    w_count_nxt = r_count + LW'(1);
                    if (r_count + LW'(1) == r_len) begin
                        w_state_nxt = HOLD;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Flush wins over everything, including a same-cycle transfer.
        if (flush) begin
            w_state_nxt   = IDLE;
            w_buf_nxt     = '0;
            w_count_nxt   = '0;
            w_len_nxt     = '0;
            w_illegal_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_buf     <= '0;
            r_count   <= '0;
            r_len     <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_buf     <= w_buf_nxt;
            r_count   <= w_count_nxt;
            r_len     <= w_len_nxt;
            r_illegal <= w_illegal_nxt;
        end
    end

    assign out_instr   = r_buf;
    assign out_len     = r_len;
    assign out_illegal = r_illegal;

endmodule

// File: tb/tb_instr_assembler.sv
// Bench for instr_assembler: directed cases with literal expectations plus a
// randomized run compared every cycle against a queue-based instruction model.
module tb_instr_assembler;

    localparam int W    = 8;
    localparam int MAXW = 3;

`ifdef IR_LEN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [7:0]  in_word;
    logic        out_ready;

    logic        in_ready, out_valid, out_illegal;
    logic [23:0] out_instr;
    logic [1:0]  out_len;

    logic        in_ready2, out_valid2, out_illegal2;
    logic [15:0] out_instr2;
    logic [1:0]  out_len2;

    int errors = 0;
    int checks = 0;

    instr_assembler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_word     (in_word),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_len     (out_len),
        .out_illegal (out_illegal)
    );

    instr_assembler #(.MAX_WORDS(2)) dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready2),
        .in_word     (in_word),
        .out_valid   (out_valid2),
        .out_ready   (out_ready),
        .out_instr   (out_instr2),
        .out_len     (out_len2),
        .out_illegal (out_illegal2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic setin(input logic fl, input logic iv, input logic [7:0] w, input logic ordy);
        flush     = fl;
        in_valid  = iv;
        in_word   = w;
        out_ready = ordy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    // Words taken so far for the instruction being built, and the instruction
    // currently offered to the decoder (if any).
    int          m_cur[$];
    int          m_target;
    bit          m_cur_ill;
    bit          m_held;
    logic [23:0] m_instr;
    int          m_len;
    bit          m_ill;

    function automatic logic [23:0] pack(input int q[$]);
        logic [23:0] r;
        r = '0;
        foreach (q[i]) r = r | (24'(q[i]) << ((MAXW - 1 - i) * W));
        return r;
    endfunction

    initial begin
        m_held = 0; m_instr = '0; m_len = 0; m_ill = 0; m_target = 1; m_cur_ill = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_cur.delete();
                m_held = 0;
            end else if (flush) begin
                m_cur.delete();
                m_held = 0;
            end else begin
                bit rdy;
                int f;
                rdy = m_held ? out_ready : 1'b1;
                if (m_held && out_ready) m_held = 0;
                if (in_valid && rdy) begin
                    m_cur.push_back(int'(in_word));
                    if (m_cur.size() == 1) begin
                        f         = int'(in_word[7:6]) + 1;
                        m_target  = (f > MAXW) ? MAXW : f;
                        m_cur_ill = CHK && (f > MAXW);
                    end
                    if (m_cur.size() == m_target) begin
                        m_held  = 1;
                        m_instr = pack(m_cur);
                        m_len   = m_target;
                        m_ill   = m_cur_ill;
                        m_cur.delete();
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("in_ready", 32'(in_ready), 32'(m_held ? out_ready : 1'b1));
                chk("out_valid", 32'(out_valid), 32'(m_held));
                if (m_held) begin
                    chk("out_instr", 32'(out_instr), 32'(m_instr));
                    chk("out_len", 32'(out_len), 32'(m_len));
                    chk("out_illegal", 32'(out_illegal), 32'(m_ill));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit         pend;
        logic [7:0] hw;
        logic       iv, fl, ordy;
        logic [7:0] w;

        rst_n = 1'b0;
        setin(0, 0, 8'h00, 0);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", 32'(out_instr), 32'd0);
        chk("rst_out_len", 32'(out_len), 32'd0);
        chk("rst_out_illegal", 32'(out_illegal), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        step();

        // 1: single-word instruction
        setin(0, 1, 8'h05, 1); step();
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_len", 32'(out_len), 32'd1);
        chk("t1_instr", 32'(out_instr), 32'h050000);
        setin(0, 0, 8'h00, 1); step();
        chk("t1_drop", 32'(out_valid), 32'd0);

        // 2: three words back-to-back
        setin(0, 1, 8'h81, 1); step();
        setin(0, 1, 8'hAA, 1); step();
        chk("t2_not_yet", 32'(out_valid), 32'd0);
        setin(0, 1, 8'hBB, 1); step();
        chk("t2_valid", 32'(out_valid), 32'd1);
        chk("t2_instr", 32'(out_instr), 32'h81AABB);
        chk("t2_len", 32'(out_len), 32'd3);
        setin(0, 0, 8'h00, 1); step();

        // 3: decoder stall, then consume with next word 0 in the same cycle
        setin(0, 1, 8'h40, 0); step();
        setin(0, 1, 8'h11, 0); step();
        setin(0, 1, 8'h02, 0); #1;
        chk("t3_stall_rdy", 32'(in_ready), 32'd0);
        chk("t3_instr", 32'(out_instr), 32'h401100);
        step();
        chk("t3_stable", 32'(out_instr), 32'h401100);
        chk("t3_still_valid", 32'(out_valid), 32'd1);
        setin(0, 1, 8'h02, 1); #1;
        chk("t3_rdy", 32'(in_ready), 32'd1);
        step();
        chk("t3_next_valid", 32'(out_valid), 32'd1);
        chk("t3_next_instr", 32'(out_instr), 32'h020000);
        chk("t3_next_len", 32'(out_len), 32'd1);
        setin(0, 0, 8'h00, 1); step();

        // 4: flush mid-instruction discards a same-cycle word
        setin(0, 1, 8'hC3, 1); step();
        setin(0, 1, 8'h55, 1); step();
        setin(1, 1, 8'h99, 1); step();
        chk("t4_valid", 32'(out_valid), 32'd0);
        chk("t4_rdy", 32'(in_ready), 32'd1);
        chk("t4_instr", 32'(out_instr), 32'd0);
        setin(0, 1, 8'h01, 1); step();
        chk("t4_instr2", 32'(out_instr), 32'h010000);
        chk("t4_len2", 32'(out_len), 32'd1);
        setin(0, 0, 8'h00, 1); step();

        // 5: two-word geometry with an overlong length field
        setin(1, 0, 8'h00, 1); step();
        setin(0, 1, 8'hC0, 1); step();
        setin(0, 1, 8'h77, 1); step();
        chk("t5_valid", 32'(out_valid2), 32'd1);
        chk("t5_len", 32'(out_len2), 32'd2);
        chk("t5_instr", 32'(out_instr2), 32'hC077);
        chk("t5_illegal", 32'(out_illegal2), 32'(CHK));
        setin(1, 0, 8'h00, 1); step();
        setin(0, 0, 8'h00, 1); step();

        // 6: asynchronous reset mid-collection
        setin(0, 1, 8'h81, 1); step();
        setin(0, 1, 8'h22, 1); step();
        setin(0, 0, 8'h00, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rdy", 32'(in_ready), 32'd1);
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_instr", 32'(out_instr), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        step();
        setin(0, 1, 8'h05, 1); step();
        chk("t6_word0_valid", 32'(out_valid), 32'd1);
        chk("t6_word0_instr", 32'(out_instr), 32'h050000);
        setin(0, 0, 8'h00, 1); step();

        // Randomized run; a refused word is held by the source until taken.
        pend = 0;
        hw   = 8'h00;
        repeat (3000) begin
            fl   = ($urandom_range(0, 39) == 0);
            ordy = ($urandom_range(0, 2) != 0);
            if (pend) begin
                iv = 1'b1;
                w  = hw;
            end else begin
                iv = ($urandom_range(0, 3) != 0);
                w  = 8'($urandom);
            end
            setin(fl, iv, w, ordy);
            #2;
            pend = iv && !in_ready;
            hw   = w;
            step();
        end

        setin(0, 0, 8'h00, 1);
        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
